alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 25 ++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: two packed requester channels plus the shared response.
// master = requesters, slave = arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [7:0]          req_op;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [DATA_W-1:0]   resp_result;
    logic                resp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared external ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif
    logic              grant;

    // Winner index; only meaningful while at least one req_valid bit is set.
    always_comb begin
        grant = 1'b0;
        if (bus.req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        owner_d        = owner_q;
        result_d       = result_q;
        zero_d         = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d   = last_grant_q;
`endif
        bus.req_ready  = 2'b00;
        bus.resp_valid = 2'b00;

        case (state_q)
            IDLE: begin
                // Ready is only raised on a valid bit, so raising it means acceptance.
                if (|bus.req_valid) begin
                    bus.req_ready = grant ? 2'b10 : 2'b01;
                    a_d     = grant ? bus.req_a[DATA_W +: DATA_W] : bus.req_a[0 +: DATA_W];
                    b_d     = grant ? bus.req_b[DATA_W +: DATA_W] : bus.req_b[0 +: DATA_W];
                    op_d    = grant ? bus.req_op[7:4] : bus.req_op[3:0];
                    owner_d = grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = grant;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                bus.resp_valid = owner_q ? 2'b10 : 2'b01;
                if (bus.resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            owner_q      <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign alu_op          = op_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: vector table, scoreboard and multi-cycle corner sequences,
// with a behavioural model standing in for the shared ALU.
module tb_alu_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DW)) bus ();
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [3:0]    alu_op;
    logic          alu_zero, busy;

    alu_arbiter #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_zero  (alu_zero),
        .busy      (busy)
    );

    function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic [31:0] r;
        sa = a;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    r = a << b[4:0];
            4'd7:    r = a >> b[4:0];
            4'd8:    r = (a < b) ? 32'd1 : 32'd0;
            4'd9:    r = sa >>> b[4:0];
            default: r = {28'hDEADBEE, op};
        endcase
        return r;
    endfunction

    assign alu_result = alu_model(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    typedef struct {
        logic        owner;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;
    int   rr_order[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout/none expected event", nm);
    endtask

    function automatic int find_sb(logic owner);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].owner == owner) return i;
        return -1;
    endfunction

    task automatic drive(int r, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] res, logic z);
        exp_t e;
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
        bus.req_op[r*4 +: 4]  = op;
        bus.req_valid[r]      = 1'b1;
        e = '{owner: r[0], op: op, a: a, b: b, res: res, z: z};
        sb.push_back(e);
        #1;
    endtask

    // mode 0: keep requests held, 1: drop winner's request, 2: drop all requests
    task automatic accept_exec(int mode, output int who);
        int n;
        int idx;
        n   = 0;
        who = 0;
        while (n < 20 && (bus.req_valid & bus.req_ready) == 2'b00) begin
            tick();
            n++;
        end
        if ((bus.req_valid & bus.req_ready) == 2'b00) begin
            fail_now("accept_timeout");
            return;
        end
        chk("req_ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
        who = bus.req_ready[1] ? 1 : 0;
        tick();
        if (mode == 1) bus.req_valid[who] = 1'b0;
        else if (mode == 2) bus.req_valid = 2'b00;
        if (mode != 0) begin
            bus.req_a[who*32 +: 32] = $urandom();
            bus.req_b[who*32 +: 32] = $urandom();
            bus.req_op[who*4 +: 4]  = 4'($urandom());
        end
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_req_ready", bus.req_ready, 2'b00);
        chk("exec_resp_valid", bus.resp_valid, 2'b00);
        idx = find_sb(who[0]);
        if (idx >= 0) begin
            chk("exec_alu_a", alu_a, sb[idx].a);
            chk("exec_alu_b", alu_b, sb[idx].b);
            chk("exec_alu_op", alu_op, sb[idx].op);
        end
    endtask

    task automatic respond(int hold);
        int   n;
        int   idx;
        logic w;
        exp_t e;
        n = 0;
        while (n < 20 && bus.resp_valid == 2'b00) begin
            tick();
            n++;
        end
        if (bus.resp_valid == 2'b00) begin
            fail_now("resp_timeout");
            return;
        end
        chk("resp_valid_onehot", 64'($countones(bus.resp_valid)), 64'd1);
        w   = bus.resp_valid[1];
        idx = find_sb(w);
        if (idx < 0) begin
            fail_now("resp_unexpected_owner");
        end else begin
            e = sb[idx];
            sb.delete(idx);
            chk("resp_result", bus.resp_result, e.res);
            chk("resp_zero", bus.resp_zero, e.z);
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_result", bus.resp_result, e.res);
                chk("hold_valid", bus.resp_valid, {w, ~w});
                chk("hold_req_ready", bus.req_ready, 2'b00);
                chk("hold_busy", busy, 1);
            end
        end
        bus.resp_ready = w ? 2'b10 : 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        chk("post_resp_busy", busy, 0);
        chk("post_resp_valid", bus.resp_valid, 2'b00);
    endtask

    task automatic serve(int mode, int hold, output int who);
        accept_exec(mode, who);
        tick();
        chk("resp_latency", bus.resp_valid, (who == 1) ? 2'b10 : 2'b01);
        respond(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int r;

        vecs[0]  = '{4'd0,  32'd10,        32'd20,        32'd30,        1'b0};
        vecs[1]  = '{4'd1,  32'd5,         32'd7,         32'hFFFFFFFE,  1'b0};
        vecs[2]  = '{4'd2,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0};
        vecs[3]  = '{4'd3,  32'h0F0F0000,  32'h000000F0,  32'h0F0F00F0,  1'b0};
        vecs[4]  = '{4'd4,  32'h00001234,  32'h00001234,  32'h00000000,  1'b1};
        vecs[5]  = '{4'd5,  32'h80000000,  32'd1,         32'd1,         1'b0};
        vecs[6]  = '{4'd5,  32'd5,         32'd3,         32'd0,         1'b1};
        vecs[7]  = '{4'd6,  32'd1,         32'd31,        32'h80000000,  1'b0};
        vecs[8]  = '{4'd7,  32'h80000000,  32'd4,         32'h08000000,  1'b0};
        vecs[9]  = '{4'd8,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b1};
        vecs[10] = '{4'd8,  32'd1,         32'hFFFFFFFF,  32'd1,         1'b0};
        vecs[11] = '{4'd9,  32'h80000000,  32'd4,         32'hF8000000,  1'b0};
        vecs[12] = '{4'd12, 32'd5,         32'd6,         32'hDEADBEEC,  1'b0};
        vecs[13] = '{4'd15, 32'd0,         32'd0,         32'hDEADBEEF,  1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
        rr_order = '{0, 0, 0, 0};
`else
        rr_order = '{0, 1, 0, 1};
`endif

        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_resp_result", bus.resp_result, 0);
        chk("rst_resp_zero", bus.resp_zero, 0);

        for (int i = 0; i < 14; i++) begin
            drive(i % 2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z);
            chk("vec_req_ready", bus.req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            serve(1, 0, who);
            chk("vec_grant", who, i % 2);
        end

        for (int i = 0; i < 6; i++) begin
            r   = int'($urandom_range(0, 1));
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom();
            rb  = $urandom();
            drive(r, rop, ra, rb, alu_model(rop, ra, rb), alu_model(rop, ra, rb) == 0);
            serve(1, 0, who);
            chk("rand_grant", who, r);
        end

        // Contention right after reset: requester 0 goes first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 4'd1, 32'd20, 32'd20, 32'd0, 1'b1);
        drive(1, 4'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
        serve(1, 0, who);
        chk("contend_first", who, 0);
        serve(1, 0, who);
        chk("contend_second", who, 1);

        // Both requesters held valid across four operations
        bus.req_a[31:0]  = 32'd1; bus.req_b[31:0]  = 32'd2; bus.req_op[3:0] = 4'd0;
        bus.req_a[63:32] = 32'd4; bus.req_b[63:32] = 32'd8; bus.req_op[7:4] = 4'd3;
        bus.req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rr_order[i] == 1) sb.push_back('{1'b1, 4'd3, 32'd4, 32'd8, 32'hC, 1'b0});
            else                  sb.push_back('{1'b0, 4'd0, 32'd1, 32'd2, 32'd3, 1'b0});
            accept_exec((i == 3) ? 2 : 0, who);
            chk("rr_grant", who, rr_order[i]);
            tick();
            chk("rr_resp_latency", bus.resp_valid, (who == 1) ? 2'b10 : 2'b01);
            respond(0);
        end
        sb.delete();

        // Backpressure on requester 1 with requester 0 waiting
        drive(1, 4'd9, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
        accept_exec(1, who);
        chk("bp_grant", who, 1);
        drive(0, 4'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0);
        chk("bp_exec_req_ready", bus.req_ready, 2'b00);
        tick();
        chk("bp_resp_valid", bus.resp_valid, 2'b10);
        respond(5);
        serve(1, 0, who);
        chk("bp_waiter_grant", who, 0);

        // Reset during EXEC abandons the operation
        drive(0, 4'd0, 32'd7, 32'd8, 32'd15, 1'b0);
        accept_exec(1, who);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_resp_valid", bus.resp_valid, 2'b00);
        tick();
        chk("midrst_no_resp", bus.resp_valid, 2'b00);
        sb.delete();
        drive(0, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        serve(1, 0, who);
        chk("midrst_next_grant", who, 0);

        // Ready on the non-owner bit is ignored
        drive(0, 4'd3, 32'h00000011, 32'h00000100, 32'h00000111, 1'b0);
        accept_exec(1, who);
        tick();
        chk("wo_resp_valid", bus.resp_valid, 2'b01);
        bus.resp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wo_still_resp", bus.resp_valid, 2'b01);
            chk("wo_busy", busy, 1);
        end
        bus.resp_ready = 2'b00;
        respond(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
